mux8_rr_arbiter: RTL and testbench
==================================

# mux8_rr_arbiter

Round-robin arbiter that shares one 8:1 datapath multiplexer among eight requesters in the 32-bit CPU. It picks one requester at a time and drives the 3-bit mux select. It forwards the selected requester's word through a valid/ready output handshake. It caps each tenure at a configurable burst length so that no requester starves the others.

## Interface
- WIDTH, 32, data word width per requester.
- MAX_BURST, 4, maximum accepted beats per grant tenure; legal range 1..255.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; one clock domain only.
- req  in  8  request vector; req[i] is held high while requester i has a word to send.
- in_data  in  8*WIDTH  flattened input words; requester i occupies bits [i*WIDTH +: WIDTH].
- out_ready  in  1  downstream accepts out_data this cycle.
- out_valid  out  1  out_data holds a valid word.
- out_data  out  WIDTH  word of the granted requester.
- sel  out  3  registered mux select (index of the granted requester); feeds external 8:1 muxes.
- gnt  out  8  one-hot grant; all zero when idle.
- ack  out  8  one-hot beat acknowledge: ack[i] = gnt[i] & out_valid & out_ready.
- busy  out  1  high in state GRANT.

## Operation
- States: IDLE and GRANT.
- Registers:
  - state
  - sel[2:0]
  - ptr[2:0], the last granted index
  - beat_cnt[7:0]
- Pick function: this is the first set bit of req, scanning circularly from ptr+1 (mod 8) up to ptr. Index ptr has the lowest priority.
- IDLE: if req != 0, latch sel = pick, clear beat_cnt and go to GRANT. Otherwise stay in IDLE.
- GRANT:
  - gnt = 1 << sel.
  - out_valid = req[sel].
  - out_data = in_data word sel, combinational from the registered sel.
  - A beat is accepted when out_valid & out_ready. On acceptance, beat_cnt increments.
- A release happens on either of two conditions:
  - req[sel] = 0.
  - A beat is accepted while beat_cnt == MAX_BURST-1.
- On release, ptr := sel and beat_cnt := 0. Then:
  - If any req bit other than the current sel is set, grant the next pick immediately: stay in GRANT and load the new sel on the same edge.
  - Otherwise go to IDLE.
- If the released requester is the only one still requesting at a burst-limit release, it is re-granted directly. This is a new tenure, and beat_cnt restarts at 0.
- beat_cnt saturates logically at MAX_BURST-1. It never wraps within a tenure.

## Timing
- Reset values:
  - state=IDLE, sel=0, ptr=7 (so requester 0 wins first), beat_cnt=0.
  - gnt=0, ack=0, out_valid=0, busy=0, out_data=0.
- Grant latency: the first req rising in IDLE gives gnt/sel/out_valid in the next cycle (1 cycle).
- Back-to-back tenures have zero idle cycles between them. The new sel is valid in the cycle after the release edge.
- out_data and out_valid are combinational from registered sel and from the req/in_data inputs. There is no extra pipeline stage.
- Requester protocol: a requester must hold req[i] and in_data stable until ack[i] for that beat. It drops req[i] only after its last ack.
- out_ready has no effect on arbitration while out_valid=0.
- Simultaneous req drop and out_ready in the same cycle: out_valid is already 0, so no beat is counted and the cycle is a release.
- Reset asserted mid-tenure: all state returns to reset values immediately (asynchronous). The in-flight beat is not acknowledged.

## Structure
- Shared package (mux8_arb_pkg):
  - state enum (IDLE, GRANT).
  - N_REQ=8.
  - SEL_W=3.
- One combinational sub-module, rr_pick8:
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: idx[2:0], any.
  - Implemented as a rotate, then a priority encode, then an un-rotate. The top level instantiates it once.
- The top level holds the FSM, the ptr/sel/beat_cnt registers, and the data select.

## Test plan
1. Reset, then req=8'h01, out_ready=1 held for 3 cycles before req drops -> gnt=8'h01 one cycle after req; ack[0] on 3 consecutive cycles; then IDLE, busy=0, ptr=0.
2. req=8'hFF held, out_ready=1, MAX_BURST=4 -> sel sequence 0,1,2,…,7,0, each granted exactly 4 beats with no idle cycle between tenures.
3. Only req[5] set, out_ready=1, continuous -> re-granted every 4 beats; sel stays 5; beat_cnt restarts at 0 each tenure.
4. req[2] granted, out_ready=0 for 5 cycles, then 1 -> out_valid=1 throughout, beat_cnt=0 while stalled, first ack on the cycle out_ready rises; out_data equals word 2 (e.g. 32'hA5A5_0002).
5. req=8'h90 after ptr=6 -> sel=7 first, then 4. Then req[7] drops after 1 beat -> immediate switch to sel=4.
6. rst_n pulsed low mid-tenure with sel=3 and beat_cnt=2 -> gnt=0, out_valid=0 without waiting for a clock edge; after release, requester 0 is picked first if requesting.

Source files
------------

// File: rtl/mux8_arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/mux8_rr_arbiter_pick.sv
// Circular first-set-bit search over eight requests, starting just after ptr.
module rr_pick8
   import mux8_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

   logic [SEL_W-1:0] start;
   logic [SEL_W-1:0] offset;
   logic [N_REQ-1:0] rot;

   // Rotate so ptr+1 lands at bit 0, encode the lowest set bit, rotate back.
   always_comb begin
      start  = ptr + SEL_W'(1);
      rot    = N_REQ'({req, req} >> start);
      offset = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (rot[j]) offset = SEL_W'(j);
      end
      idx = start + offset;
      any = |req;
   end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving a shared 8:1 mux select with per-tenure burst cap.
//
// state | meaning
// IDLE  | no requester granted; gnt, out_valid, busy low
// GRANT | requester sel owns the datapath until it drops req or hits the burst cap
module mux8_rr_arbiter
   import mux8_arb_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] in_data,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   output logic [SEL_W-1:0]       sel,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       ack,
   output logic                   busy
);

   localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

   state_t           state;
   logic [SEL_W-1:0] ptr;
   logic [7:0]       beat_cnt;

   logic [SEL_W-1:0] pick_base;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic             accept;
   logic             tenure_end;
   logic [WIDTH-1:0] words [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_words
      assign words[i] = in_data[i*WIDTH +: WIDTH];
   end

   // While granted, search from sel so a release hands over on the same edge.
   assign pick_base = busy ? sel : ptr;

   rr_pick8 u_pick (
      .req (req),
      .ptr (pick_base),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign busy       = (state == GRANT);
   assign out_valid  = busy & req[sel];
   assign out_data   = busy ? words[sel] : '0;
   assign gnt        = busy ? (N_REQ'(1) << sel) : '0;
   assign accept     = out_valid & out_ready;
   assign ack        = gnt & {N_REQ{accept}};
   assign tenure_end = busy & (~req[sel] | (accept & (beat_cnt == LAST_BEAT)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel      <= '0;
         ptr      <= SEL_W'(N_REQ - 1);
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  sel      <= pick_idx;
                  beat_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (tenure_end) begin
                  ptr      <= sel;
                  beat_cnt <= '0;
                  if (pick_any) sel   <= pick_idx;
                  else          state <= IDLE;
               end else if (accept) begin
                  beat_cnt <= beat_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with a scoreboard of expected accepted beats.
module tb_mux8_rr_arbiter;

   localparam int WIDTH = 32;
   localparam int N     = 8;

   typedef struct {
      logic [2:0]  idx;
      logic [31:0] data;
   } beat_t;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req;
   logic [N*WIDTH-1:0] in_data;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [2:0]       sel;
   logic [N-1:0]     gnt;
   logic [N-1:0]     ack;
   logic             busy;

   int     checks = 0;
   int     errors = 0;
   int     rem [N];
   int     cyc;
   logic [7:0] phase;
   beat_t  sb [$];

   mux8_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in_data   (in_data),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .sel       (sel),
      .gnt       (gnt),
      .ack       (ack),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input logic [7:0] ph);
      phase = ph;
      for (int i = 0; i < N; i++) begin
         logic [7:0] iv;
         iv = 8'(i);
         in_data[i*WIDTH +: WIDTH] = {16'hA5A5, ph, iv};
      end
   endtask

   task automatic push(input int idx, input int n);
      beat_t b;
      logic [7:0] iv;
      iv = 8'(idx);
      b.idx  = 3'(idx);
      b.data = {16'hA5A5, phase, iv};
      repeat (n) sb.push_back(b);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0;
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) rem[i] = 0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Runs until every requester has sent its beats; returns cycles used.
   task automatic run(input int budget, output int cycles);
      logic [N-1:0] acked;
      beat_t b;
      bit done;
      cycles = 0;
      done = 1'b0;
      while (!done && cycles < budget) begin
         @(negedge clk);
         cycles++;
         acked = ack;
         if (|ack) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_ack", 32'(ack), 32'h0);
            end else begin
               b = sb.pop_front();
               check("sb_ack", 32'(ack), 32'h1 << b.idx);
               check("sb_sel", 32'(sel), 32'(b.idx));
               check("sb_data", out_data, b.data);
            end
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (acked[i]) begin
               rem[i]--;
               if (rem[i] == 0) req[i] = 1'b0;
            end
         end
         if (req == '0) done = 1'b1;
      end
      check("run_done", 32'(done), 32'h1);
      check("sb_drained", sb.size(), 32'h0);
   endtask

   initial begin
      rst_n = 1'b1;
      req = '0;
      out_ready = 1'b0;
      set_data(8'h00);
      #2;
      do_reset();

      // Reset values
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_data", out_data, 32'h0);
      check("rst_sel", 32'(sel), 32'h0);

      // Single requester, three beats, one-cycle grant latency
      @(posedge clk); #1;
      set_data(8'h01);
      out_ready = 1'b1;
      req = 8'h01;
      rem[0] = 3;
      push(0, 3);
      @(negedge clk);
      check("t1_gnt_before", 32'(gnt), 32'h0);
      @(posedge clk); #1;
      run(20, cyc);
      check("t1_cycles", cyc, 3);
      @(negedge clk);
      check("t1_release_valid", 32'(out_valid), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t1_idle_busy", 32'(busy), 32'h0);
      check("t1_idle_gnt", 32'(gnt), 32'h0);
      // ptr is now 0: requester 1 must win over requester 0
      @(posedge clk); #1;
      req = 8'h03;
      rem[0] = 1;
      rem[1] = 1;
      push(1, 1);
      push(0, 1);
      run(20, cyc);
      check("t1_ptr_cycles", cyc, 4);

      // All requesting: 0..7 then 0, four beats each, no gaps
      do_reset();
      set_data(8'h02);
      out_ready = 1'b1;
      req = 8'hFF;
      for (int i = 0; i < N; i++) begin
         rem[i] = (i == 0) ? 8 : 4;
         push(i, 4);
      end
      push(0, 4);
      run(100, cyc);
      check("t2_cycles", cyc, 37);

      // Lone requester re-granted every four beats without a gap
      do_reset();
      set_data(8'h03);
      out_ready = 1'b1;
      req = 8'h20;
      rem[5] = 9;
      push(5, 9);
      run(40, cyc);
      check("t3_cycles", cyc, 10);

      // Stalled output keeps valid high, counts nothing
      @(posedge clk); #1;
      set_data(8'h00);
      out_ready = 1'b0;
      req = 8'h04;
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t4_stall_valid", 32'(out_valid), 32'h1);
         check("t4_stall_ack", 32'(ack), 32'h0);
         check("t4_stall_data", out_data, 32'hA5A5_0002);
         check("t4_stall_cnt", 32'(dut.beat_cnt), 32'h0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      rem[2] = 4;
      push(2, 4);
      run(20, cyc);
      check("t4_cycles", cyc, 4);

      // ptr=6, then req 7 and 4: 7 first, then 4 after 7 drops
      do_reset();
      set_data(8'h05);
      out_ready = 1'b1;
      req = 8'h40;
      rem[6] = 1;
      push(6, 1);
      run(20, cyc);
      @(posedge clk); #1;
      check("t5_idle_busy", 32'(busy), 32'h0);
      req = 8'h90;
      rem[7] = 1;
      rem[4] = 1;
      push(7, 1);
      push(4, 1);
      run(20, cyc);
      check("t5_cycles", cyc, 4);

      // Asynchronous reset mid-tenure
      do_reset();
      set_data(8'h06);
      out_ready = 1'b1;
      req = 8'h08;
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("t6_sel", 32'(sel), 32'h3);
      check("t6_cnt", 32'(dut.beat_cnt), 32'h2);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_gnt", 32'(gnt), 32'h0);
      check("t6_rst_valid", 32'(out_valid), 32'h0);
      check("t6_rst_ack", 32'(ack), 32'h0);
      check("t6_rst_busy", 32'(busy), 32'h0);
      req = 8'h09;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("t6_after_sel", 32'(sel), 32'h0);
      check("t6_after_gnt", 32'(gnt), 32'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
